// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: datapath widths, register-file
// geometry and the control bundle carried in the MEM/WB pipeline register.
package writeback_stage_pkg;
   localparam int DATA_W     = 8;
   localparam int REG_ADDR_W = 3;
   localparam int NREGS      = 8;
   localparam int CNT_W      = 16;

   typedef struct packed {
      logic valid;
      logic RegWrite;
      logic MemToReg;
   } wb_ctrl_t;
endpackage

// File: rtl/writeback_stage_regfile.sv
// regfile_2r1w: NREGS x DATA_W register file, two combinational read ports,
// one write port. Register 0 is never stored and always reads zero. A read
// whose address matches the active write returns the write data the same
// cycle (write-through).
//  clk, reset_n         clock, async active-low reset (clears all entries)
//  i_we, i_waddr, i_wdata  write port
//  i_raddr1/2           read addresses
//  o_rdata1/2           read data
module regfile_2r1w
   import writeback_stage_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_we,
   input  logic [REG_ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0]     i_wdata,
   input  logic [REG_ADDR_W-1:0] i_raddr1,
   input  logic [REG_ADDR_W-1:0] i_raddr2,
   output logic [DATA_W-1:0]     o_rdata1,
   output logic [DATA_W-1:0]     o_rdata2
);
   logic [NREGS-1:1][DATA_W-1:0] r_regs;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_regs <= '0;
      end else if (i_we && (i_waddr != '0)) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   function automatic logic [DATA_W-1:0] rd_port(input logic [REG_ADDR_W-1:0] a);
      logic [DATA_W-1:0] d;
      d = '0;
      if (a != '0) begin
         if (i_we && (a == i_waddr)) d = i_wdata;
         else                        d = r_regs[a];
      end
      return d;
   endfunction

   assign o_rdata1 = rd_port(i_raddr1);
   assign o_rdata2 = rd_port(i_raddr2);
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register, load-data alignment, result
// select, register-file commit, forwarding and retire counting.
//  clk, reset_n                 clock, async active-low reset
//  stall, flush                 hold WB entry / drop the entry being captured
//  mem_valid, mem_RegWrite,
//  mem_MemToReg, mem_rd,
//  mem_alu_result               memory-stage instruction
//  read_data                    load data, arrives one cycle after the address
//  rs1_addr/rs2_addr -> rs1_data/rs2_data   register reads with write-through
//  wb_fwd_valid/rd/data         forwarding of the value being written back
//  retire_count                 committed valid instructions, wrapping
module writeback_stage
   import writeback_stage_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  mem_valid,
   input  logic                  mem_RegWrite,
   input  logic                  mem_MemToReg,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [DATA_W-1:0]     mem_alu_result,
   input  logic [DATA_W-1:0]     read_data,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic [DATA_W-1:0]     rs1_data,
   output logic [DATA_W-1:0]     rs2_data,
   output logic                  wb_fwd_valid,
   output logic [REG_ADDR_W-1:0] wb_fwd_rd,
   output logic [DATA_W-1:0]     wb_fwd_data,
   output logic [CNT_W-1:0]      retire_count
);
   wb_ctrl_t              r_ctrl;
   logic [REG_ADDR_W-1:0] r_rd;
   logic [DATA_W-1:0]     r_alu_q;
   logic [DATA_W-1:0]     r_ld_hold;
   logic                  r_ld_held;
   logic [CNT_W-1:0]      r_retire;

   logic                  w_commit;
   logic                  w_we;
   logic [DATA_W-1:0]     w_ld_data;
   logic [DATA_W-1:0]     w_wb_data;

   assign w_commit  = r_ctrl.valid & ~stall;
   assign w_we      = w_commit & r_ctrl.RegWrite & (r_rd != '0);
   // read_data is only valid for one cycle; once a stall has parked the
   // load, the captured copy is the authoritative value.
   assign w_ld_data = r_ld_held ? r_ld_hold : read_data;
   assign w_wb_data = r_ctrl.MemToReg ? w_ld_data : r_alu_q;

   // MEM/WB register; a stall freezes it and masks flush (upstream re-flushes).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ctrl  <= '0;
         r_rd    <= '0;
         r_alu_q <= '0;
      end else if (!stall) begin
         r_ctrl.valid    <= mem_valid & ~flush;
         r_ctrl.RegWrite <= mem_RegWrite;
         r_ctrl.MemToReg <= mem_MemToReg;
         r_rd            <= mem_rd;
         r_alu_q         <= mem_alu_result;
      end
   end

   // Load hold: capture on the first stalled cycle of a valid load; any
   // unstalled edge retires (or replaces) the entry, so clear there.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ld_hold <= '0;
         r_ld_held <= 1'b0;
      end else if (!stall) begin
         r_ld_held <= 1'b0;
      end else if (r_ctrl.valid && r_ctrl.MemToReg && !r_ld_held) begin
         r_ld_hold <= read_data;
         r_ld_held <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      r_retire <= '0;
      else if (w_commit) r_retire <= r_retire + 1'b1;
   end

   regfile_2r1w u_rf (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_we     (w_we),
      .i_waddr  (r_rd),
      .i_wdata  (w_wb_data),
      .i_raddr1 (rs1_addr),
      .i_raddr2 (rs2_addr),
      .o_rdata1 (rs1_data),
      .o_rdata2 (rs2_data)
   );

   assign wb_fwd_valid = r_ctrl.valid & r_ctrl.RegWrite & (r_rd != '0);
   assign wb_fwd_rd    = r_rd;
   assign wb_fwd_data  = w_wb_data;
   assign retire_count = r_retire;
endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
   logic       clk = 1'b0;
   logic       reset_n;
   logic       stall, flush;
   logic       mem_valid, mem_RegWrite, mem_MemToReg;
   logic [2:0] mem_rd;
   logic [7:0] mem_alu_result, read_data;
   logic [2:0] rs1_addr, rs2_addr;
   logic [7:0] rs1_data, rs2_data;
   logic       wb_fwd_valid;
   logic [2:0] wb_fwd_rd;
   logic [7:0] wb_fwd_data;
   logic [15:0] retire_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   writeback_stage dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
      .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_MemToReg(mem_MemToReg),
      .mem_rd(mem_rd), .mem_alu_result(mem_alu_result), .read_data(read_data),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
      .retire_count(retire_count)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic drv(input logic v, input logic rw, input logic m2r,
                      input logic [2:0] rd, input logic [7:0] alu);
      mem_valid = v; mem_RegWrite = rw; mem_MemToReg = m2r;
      mem_rd = rd; mem_alu_result = alu;
   endtask

   task automatic bubble();
      drv(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
   endtask

   // advance one edge; inputs change and checks happen 1 time unit later
   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      reset_n = 1'b0; stall = 1'b0; flush = 1'b0; read_data = 8'h00;
      rs1_addr = 3'd0; rs2_addr = 3'd0;
      bubble();
      #12;
      chk("rst_count", retire_count, 16'h0);
      chk("rst_fwd_valid", wb_fwd_valid, 1'b0);
      chk("rst_fwd_data", wb_fwd_data, 8'h00);
      chk("rst_fwd_rd", wb_fwd_rd, 3'd0);
      chk("rst_rs1", rs1_data, 8'h00);
      reset_n = 1'b1;
      tick();

      // 1: ALU op rd=3
      drv(1, 1, 0, 3'd3, 8'h5A);
      tick();
      bubble(); rs1_addr = 3'd3; #1;
      chk("t1_fwd_valid", wb_fwd_valid, 1'b1);
      chk("t1_fwd_rd", wb_fwd_rd, 3'd3);
      chk("t1_fwd_data", wb_fwd_data, 8'h5A);
      chk("t1_bypass", rs1_data, 8'h5A);
      tick();
      chk("t1_reg3", rs1_data, 8'h5A);
      chk("t1_count", retire_count, 16'd1);
      chk("t1_fwd_bubble", wb_fwd_valid, 1'b0);

      // 2: load rd=2, data next cycle
      drv(1, 1, 1, 3'd2, 8'h40);
      tick();
      bubble(); read_data = 8'hC3; #1;
      chk("t2_fwd_data", wb_fwd_data, 8'hC3);
      tick();
      read_data = 8'h00; rs1_addr = 3'd2; #1;
      chk("t2_reg2", rs1_data, 8'hC3);
      chk("t2_count", retire_count, 16'd2);

      // 3: load rd=6 with 3-cycle stall, read_data changes after first stall cycle
      drv(1, 1, 1, 3'd6, 8'h41);
      tick();
      bubble(); stall = 1'b1; read_data = 8'hC3; rs1_addr = 3'd6; #1;
      chk("t3_fwd_first", wb_fwd_data, 8'hC3);
      tick();
      read_data = 8'h11; #1;
      chk("t3_fwd_held", wb_fwd_data, 8'hC3);
      chk("t3_fwd_valid_stall", wb_fwd_valid, 1'b1);
      tick();
      tick();
      stall = 1'b0; #1;
      chk("t3_count_stalled", retire_count, 16'd2);
      chk("t3_fwd_after", wb_fwd_data, 8'hC3);
      tick();
      chk("t3_reg6", rs1_data, 8'hC3);
      chk("t3_count", retire_count, 16'd3);

      // 4: flushed capture
      drv(1, 1, 0, 3'd4, 8'h77); flush = 1'b1;
      tick();
      bubble(); flush = 1'b0; rs1_addr = 3'd4; #1;
      chk("t4_fwd_valid", wb_fwd_valid, 1'b0);
      tick();
      chk("t4_reg4", rs1_data, 8'h00);
      chk("t4_count", retire_count, 16'd3);

      // 5: rd=0, then write-through on rd=5
      drv(1, 1, 0, 3'd0, 8'hFF);
      tick();
      bubble(); rs1_addr = 3'd0; #1;
      chk("t5_fwd_valid_rd0", wb_fwd_valid, 1'b0);
      chk("t5_rs1_zero", rs1_data, 8'h00);
      tick();
      chk("t5_count_rd0", retire_count, 16'd4);
      drv(1, 1, 0, 3'd5, 8'h3C);
      tick();
      bubble(); rs1_addr = 3'd5; rs2_addr = 3'd0; #1;
      chk("t5_wthru", rs1_data, 8'h3C);
      chk("t5_rs2_zero", rs2_data, 8'h00);
      tick();
      rs2_addr = 3'd5; #1;
      chk("t5_reg5", rs2_data, 8'h3C);
      chk("t5_count", retire_count, 16'd5);

      // stall and flush together while a bubble sits in WB: nothing captured
      drv(1, 1, 0, 3'd7, 8'h99); stall = 1'b1; flush = 1'b1;
      tick();
      bubble(); stall = 1'b0; flush = 1'b0; rs1_addr = 3'd7; #1;
      chk("sf_fwd_valid", wb_fwd_valid, 1'b0);
      tick();
      chk("sf_reg7", rs1_data, 8'h00);
      chk("sf_count", retire_count, 16'd5);

      // 6: reset mid-stall with a load held
      drv(1, 1, 1, 3'd1, 8'h42);
      tick();
      bubble(); stall = 1'b1; read_data = 8'hAB;
      tick();
      read_data = 8'h22; rs1_addr = 3'd3; rs2_addr = 3'd6; #1;
      chk("t6_pre_fwd", wb_fwd_data, 8'hAB);
      reset_n = 1'b0; #1;
      chk("t6_count", retire_count, 16'd0);
      chk("t6_fwd_valid", wb_fwd_valid, 1'b0);
      chk("t6_reg3", rs1_data, 8'h00);
      chk("t6_reg6", rs2_data, 8'h00);
      chk("t6_fwd_data", wb_fwd_data, 8'h00);
      #2; reset_n = 1'b1; stall = 1'b0;

      // counter wrap: 65535 commits to 0xFFFF, one more wraps
      drv(1, 0, 0, 3'd0, 8'h00);
      tick();
      chk("wrap_start", retire_count, 16'd0);
      repeat (65535) tick();
      chk("wrap_ffff", retire_count, 16'hFFFF);
      bubble();
      tick();
      chk("wrap_zero", retire_count, 16'h0000);
      tick();
      chk("wrap_bubble", retire_count, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
